// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC multiplexed-bus responder.
// Holds the bus FSM states, pin bundle and direction codes.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_A_SETUP  = 4'd1,
    S_A_STROBE = 4'd2,
    S_A_HOLD   = 4'd3,
    S_GAP      = 4'd4,
    S_D_SETUP  = 4'd5,
    S_D_STROBE = 4'd6,
    S_D_HOLD   = 4'd7,
    S_DONE     = 4'd8
  } state_e;

  typedef struct packed {
    logic       cs_n;
    logic       ad;
    logic       wr_n;
    logic       rd_n;
    logic       oe;
    logic [7:0] ad_out;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    cs_n:   1'b1,
    ad:     1'b1,
    wr_n:   1'b1,
    rd_n:   1'b1,
    oe:     1'b0,
    ad_out: 8'h00
  };

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  // Successor of a timed phase; IDLE and DONE are sequenced by the FSM.
  function automatic state_e next_phase(input state_e s);
    state_e n;
    n = S_IDLE;
    unique case (s)
      S_A_SETUP:  n = S_A_STROBE;
      S_A_STROBE: n = S_A_HOLD;
      S_A_HOLD:   n = S_GAP;
      S_GAP:      n = S_D_SETUP;
      S_D_SETUP:  n = S_D_STROBE;
      S_D_STROBE: n = S_D_HOLD;
      S_D_HOLD:   n = S_DONE;
      default:    n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Per-phase down counter for the RTC bus FSM.
// Loads T_PHASE-1 on phase entry; expire marks the last cycle.
module phase_timer #(
  parameter int T_PHASE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expire
);

  // T_PHASE=1 needs no count, but keep one bit so the vector is legal.
  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(T_PHASE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-byte read/write responder driving the RTC multiplexed bus.
// Pins are registered and decoded from the next state.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rtc_cs_n,
  output logic       rtc_ad,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  pins_t      pins_q, pins_d;
  logic       load;
  logic       expire;

  phase_timer #(
    .T_PHASE(T_PHASE)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_wr || req_rd) begin
          state_d = S_A_SETUP;
          dir_d   = req_wr ? DIR_WR : DIR_RD;
          addr_d  = addr;
          data_d  = wr_data;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (expire) state_d = next_phase(state_q);
      end
    endcase
    if (state_q == S_D_STROBE && expire && dir_q == DIR_RD) begin
      rd_data_d = ad_in;
    end
  end

  assign load = (state_d != state_q);

  // Decode from next state so pins move on the same edge as the FSM.
  always_comb begin
    pins_d = PINS_IDLE;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    unique case (state_d)
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        pins_d.cs_n   = 1'b0;
        pins_d.ad     = 1'b0;
        pins_d.oe     = 1'b1;
        pins_d.ad_out = addr_d;
        pins_d.wr_n   = (state_d != S_A_STROBE);
      end
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        pins_d.cs_n = 1'b0;
        pins_d.ad   = 1'b1;
        if (dir_d == DIR_WR) begin
          pins_d.oe     = 1'b1;
          pins_d.ad_out = data_d;
          pins_d.wr_n   = (state_d != S_D_STROBE);
        end else begin
          pins_d.rd_n   = (state_d != S_D_STROBE);
        end
      end
      default: pins_d = PINS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_RD;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      rd_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pins_q    <= PINS_IDLE;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pins_q    <= pins_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rtc_cs_n = pins_q.cs_n;
  assign rtc_ad   = pins_q.ad;
  assign rtc_wr_n = pins_q.wr_n;
  assign rtc_rd_n = pins_q.rd_n;
  assign ad_oe    = pins_q.oe;
  assign ad_out   = pins_q.ad_out;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-side responder for the clock/date/timer FSM. It takes single-byte read or write requests (register address plus data) and runs the complete multiplexed address/data bus cycle to the external RTC chip. The multiplexed bus is driven through the chip's pins: chip select, A/D select, WR and RD strobes, and a shared 8-bit AD bus. The block sits between the control FSM and the top-level pads, and hides all bus phase timing from the FSM.

## Interface
- T_PHASE, 10: clock cycles per bus phase (≥1); 10 gives 100 ns at 100 MHz.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_wr  in  1  write request; sampled only in IDLE.
- req_rd  in  1  read request; sampled only in IDLE. req_wr wins if both are high.
- addr  in  8  RTC register address; latched on accept.
- wr_data  in  8  write data; latched on accept.
- busy  out  1  high from accept through the DONE cycle.
- done  out  1  one-cycle pulse at the end of every transaction.
- rd_data  out  8  byte captured on a read; holds until the next read completes.
- rtc_cs_n  out  1  chip select, active low.
- rtc_ad  out  1  A/D select: 0 = address phase, 1 = data phase.
- rtc_wr_n  out  1  write strobe, active low; also latches the address.
- rtc_rd_n  out  1  read strobe, active low.
- ad_out  out  8  value driven onto the AD bus.
- ad_oe  out  1  AD tristate enable; 1 = drive.
- ad_in  in  8  AD bus readback from the pad.

## Operation
- States, in order: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE.
- Each non-IDLE/non-DONE state lasts exactly T_PHASE cycles, timed by a phase counter. DONE lasts 1 cycle, then the FSM returns to IDLE.
- Accepting a request latches addr, wr_data and the direction bit.
- IDLE/DONE pin values: cs_n=1, ad=1, wr_n=1, rd_n=1, oe=0, ad_out=0.
- A_SETUP: cs_n=0, ad=0, oe=1, ad_out=addr.
- A_STROBE: same as A_SETUP, plus wr_n=0.
- A_HOLD: wr_n=1; address still driven.
- GAP: cs_n=1, ad=1, oe=0.
- D_SETUP: cs_n=0, ad=1.
  - Write: oe=1, ad_out=data.
  - Read: oe=0.
- D_STROBE: write asserts wr_n=0; read asserts rd_n=0.
- D_HOLD: strobes high.
  - Write: still drives data.
  - Read: oe=0.
- Read capture: rd_data <= ad_in on the last cycle of D_STROBE.
- done=1 only in DONE.
- rd_n and wr_n are never low together. oe is never 1 while rd_n=0.
- Requests arriving while busy=1 are ignored, not queued.

## Timing
- All pin outputs are registered and decoded from next_state, so pins change on the same edge as the state. No glitches.
- Reset (asynchronous, any time, including mid-cycle): state=IDLE, counter=0, rd_data=0, busy=0, done=0, all pins at their IDLE values. No partial bus cycle resumes after reset is released.
- Request high at edge E0 in IDLE: the A_SETUP pin values appear at E0. done=1 in cycle E0+7·T_PHASE. IDLE is re-entered at E0+7·T_PHASE+1.
- Total latency: 7·T_PHASE+1 cycles. The earliest back-to-back accept is at edge E0+7·T_PHASE+1.
- Address valid on the bus for 3·T_PHASE cycles around a T_PHASE-wide wr_n pulse.
- Data phase has the same shape: T_PHASE setup, strobe and hold.
- T_PHASE=1 is legal: each phase is 1 cycle, total latency 8 cycles.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enum (4-bit encoding);
  - the IDLE pin constants;
  - the direction encoding (DIR_WR=1, DIR_RD=0).
- Sub-module phase_timer.
  - Parameter: T_PHASE.
  - Ports: clock, reset, load, expire.
  - Counts T_PHASE-1 down to 0; expire is high on the final cycle.
  - Counter width $clog2(T_PHASE).
- The top level holds the FSM, the request latches and the registered pin decode.

## Test plan
- Write, T_PHASE=2, addr=8'h21, data=8'h45 → ad=0 and ad_out=21 for 6 cycles; wr_n low in cycles 3–4; data phase drives 45 with wr_n low for 2 cycles; done pulses at cycle 14; busy low at cycle 15.
- Read, T_PHASE=2, addr=8'h22, ad_in=8'h59 during D_STROBE → rd_n low 2 cycles, oe=0 throughout the data phase, rd_data=59 when done pulses, rd_n and wr_n never low together.
- req_wr and req_rd both high in IDLE → write performed; rd_data unchanged.
- req_wr pulsed at cycle 5 of an active transaction → ignored; exactly one done; next request is accepted only once the FSM is back in IDLE.
- reset asserted mid-D_STROBE of a write → pins return to IDLE values asynchronously, before the next clock edge; no done; a fresh read afterwards completes normally.
- T_PHASE=1 read → latency 8 cycles; strobe exactly 1 cycle wide.
